fsmlock_ctrl: RTL and testbench

- Sequencing controller for the serial combination lock.
- Collects CODE_LEN-bit entry frames from a serial din/din_valid stream and compares each frame to a stored code.
- On a match it drives a timed unlock window. It counts consecutive failed attempts and forces a timed lockout after MAX_FAILS.
- The stored code can be re-programmed only while the lock is open.

---
 rtl/fsmlock_ctrl_if.sv | 26 ++
 rtl/fsmlock_ctrl.sv | 138 +++++++++++++
 tb/tb_fsmlock_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsmlock_ctrl_if.sv
// Handshake bundle between a lock front end and fsmlock_ctrl.
// master drives entry bits and code loads; slave (the controller) drives status.
interface fsmlock_ctrl_if #(
    parameter int unsigned CODE_LEN = 4
) ();
    logic                din;
    logic                din_valid;
    logic                abort;
    logic                code_load;
    logic [CODE_LEN-1:0] code_in;
    logic                unlocked;
    logic                fail_pulse;
    logic                locked_out;
    logic [3:0]          fail_cnt;
    logic                busy;

    modport master (
        output din, din_valid, abort, code_load, code_in,
        input  unlocked, fail_pulse, locked_out, fail_cnt, busy
    );

    modport slave (
        input  din, din_valid, abort, code_load, code_in,
        output unlocked, fail_pulse, locked_out, fail_cnt, busy
    );
endinterface

// File: rtl/fsmlock_ctrl.sv
// Serial combination-lock sequencer: frame collection, timed unlock window, failure lockout.
// Optional macro FSMLOCK_CTRL_ENTRY_TIMEOUT_EN abandons a partial frame after an idle gap.
module fsmlock_ctrl #(
    parameter int unsigned         CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1011,
    parameter int unsigned         MAX_FAILS      = 3,
    parameter int unsigned         UNLOCK_CYCLES  = 8,
    parameter int unsigned         LOCKOUT_CYCLES = 16,
    parameter int unsigned         TIMEOUT_CYCLES = 32
) (
    input logic           clk,
    input logic           reset,
    fsmlock_ctrl_if.slave bus_io
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCollect = 3'd1;
    localparam logic [2:0] StCheck   = 3'd2;
    localparam logic [2:0] StFail    = 3'd3;
    localparam logic [2:0] StUnlock  = 3'd4;
    localparam logic [2:0] StLockout = 3'd5;

    localparam int unsigned CW     = $clog2(CODE_LEN + 1);
    localparam int unsigned TMAX_A = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                      : LOCKOUT_CYCLES;
    localparam int unsigned TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
    localparam int unsigned TW     = $clog2(TMAX + 1);

    logic [2:0]          state_q, state_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [CODE_LEN-1:0] shift_q, shift_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]          fail_cnt_q, fail_cnt_d;
    // Shared by the unlock window, the lockout and (optionally) the entry gap counter.
    logic [TW-1:0]       timer_q, timer_d;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        case (state_q)
            StIdle: begin
                if (bus_io.din_valid) begin
                    shift_d   = CODE_LEN'(bus_io.din);
                    bit_cnt_d = CW'(1);
                    timer_d   = '0;
                    state_d   = (CODE_LEN == 1) ? StCheck : StCollect;
                end
            end
            StCollect: begin
                if (bus_io.abort) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = StIdle;
                end else if (bus_io.din_valid) begin
                    shift_d   = CODE_LEN'({shift_q, bus_io.din});
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    timer_d   = '0;
                    if (bit_cnt_q == CW'(CODE_LEN - 1)) begin
                        state_d = StCheck;
                    end
                end
`ifdef FSMLOCK_CTRL_ENTRY_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    timer_d   = '0;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end
            StCheck: begin
                bit_cnt_d = '0;
                timer_d   = '0;
                if (shift_q == code_q) begin
                    fail_cnt_d = '0;
                    state_d    = StUnlock;
                end else begin
                    fail_cnt_d = (fail_cnt_q == 4'hF) ? fail_cnt_q : fail_cnt_q + 4'd1;
                    state_d    = StFail;
                end
            end
            StFail: begin
                timer_d = '0;
                state_d = (fail_cnt_q == 4'(MAX_FAILS)) ? StLockout : StIdle;
            end
            StUnlock: begin
                if (bus_io.code_load) begin
                    code_d = bus_io.code_in;
                end
                if (timer_q == TW'(UNLOCK_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StLockout: begin
                if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    fail_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            code_q     <= DEFAULT_CODE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            fail_cnt_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        bus_io.unlocked   = (state_q == StUnlock);
        bus_io.fail_pulse = (state_q == StFail);
        bus_io.locked_out = (state_q == StLockout);
        bus_io.busy       = (state_q == StCollect);
        bus_io.fail_cnt   = fail_cnt_q;
    end
endmodule

// File: tb/tb_fsmlock_ctrl.sv
// Bench for fsmlock_ctrl: vector table, directed multi-cycle sequences, then random traffic
// against a queue-based behavioural model of the lock.
module tb_fsmlock_ctrl;
    localparam int CODE_LEN       = 4;
    localparam int MAX_FAILS      = 3;
    localparam int UNLOCK_CYCLES  = 8;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int TIMEOUT_CYCLES = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fsmlock_ctrl_if #(.CODE_LEN(CODE_LEN)) bus_if ();

    fsmlock_ctrl #(
        .CODE_LEN      (CODE_LEN),
        .DEFAULT_CODE  (4'b1011),
        .MAX_FAILS     (MAX_FAILS),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       dv;
        logic       din;
        logic       ab;
        logic       ld;
        logic [3:0] ci;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[19];

    // Output vector layout: {unlocked, fail_pulse, locked_out, busy, fail_cnt}.
    function automatic logic [7:0] ex(bit u, bit f, bit l, bit b, int c);
        return {u, f, l, b, 4'(c)};
    endfunction

    function automatic vec_t mkv(logic dv, logic din, logic ab, logic [7:0] e);
        vec_t v;
        v.dv = dv; v.din = din; v.ab = ab; v.ld = 1'b0; v.ci = 4'h0; v.exp = e;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {bus_if.unlocked, bus_if.fail_pulse, bus_if.locked_out, bus_if.busy,
                bus_if.fail_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every step starts and ends on a falling edge.
    task automatic step(input logic dv, input logic d, input logic ab, input logic ld,
                        input logic [3:0] ci);
        bus_if.din_valid = dv;
        bus_if.din       = d;
        bus_if.abort     = ab;
        bus_if.code_load = ld;
        bus_if.code_in   = ci;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic send(input logic [3:0] f);
        for (int i = 3; i >= 0; i--) step(1'b1, f[i], 1'b0, 1'b0, 4'h0);
    endtask

    // Behavioural model: collected bits in a queue, countdowns for the timed windows.
    bit         m_frame[$];
    int         m_unlock, m_lock, m_fails, m_gap;
    bit         m_check, m_fail;
    logic [3:0] m_code;

    task automatic model_reset();
        m_frame.delete();
        m_unlock = 0; m_lock = 0; m_fails = 0; m_gap = 0;
        m_check = 0; m_fail = 0; m_code = 4'b1011;
    endtask

    function automatic int frame_val();
        int v = 0;
        foreach (m_frame[i]) v = v * 2 + int'(m_frame[i]);
        return v;
    endfunction

    function automatic logic [7:0] model_outs();
        return {m_unlock > 0, m_fail, m_lock > 0, (m_frame.size() > 0) && !m_check,
                4'(m_fails)};
    endfunction

    task automatic model_step(input bit dv, input bit d, input bit ab, input bit ld,
                              input logic [3:0] ci);
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (m_unlock > 0) begin
            if (ld) m_code = ci;
            m_unlock--;
        end else if (m_fail) begin
            m_fail = 0;
            if (m_fails == MAX_FAILS) m_lock = LOCKOUT_CYCLES;
        end else if (m_check) begin
            m_check = 0;
            if (frame_val() == int'(m_code)) begin
                m_fails  = 0;
                m_unlock = UNLOCK_CYCLES;
            end else begin
                m_fails = (m_fails < 15) ? m_fails + 1 : 15;
                m_fail  = 1;
            end
            m_frame.delete();
        end else if (m_frame.size() > 0) begin
            if (ab) begin
                m_frame.delete();
            end else if (dv) begin
                m_frame.push_back(d);
                m_gap = 0;
                if (m_frame.size() == CODE_LEN) m_check = 1;
            end else begin
                m_gap++;
`ifdef FSMLOCK_CTRL_ENTRY_TIMEOUT_EN
                if (m_gap == TIMEOUT_CYCLES) m_frame.delete();
`endif
            end
        end else if (dv) begin
            m_frame.push_back(d);
            m_gap = 0;
            if (m_frame.size() == CODE_LEN) m_check = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt_lock, seen_busy, seen_unl, cnt_unl, seen_fail;
        bus_if.din = 0; bus_if.din_valid = 0; bus_if.abort = 0;
        bus_if.code_load = 0; bus_if.code_in = '0;

        // Correct frame, then one wrong frame.
        vecs[0]  = mkv(1, 1, 0, ex(0, 0, 0, 1, 0));
        vecs[1]  = mkv(1, 0, 0, ex(0, 0, 0, 1, 0));
        vecs[2]  = mkv(1, 1, 0, ex(0, 0, 0, 1, 0));
        vecs[3]  = mkv(1, 1, 0, ex(0, 0, 0, 0, 0));
        vecs[4]  = mkv(0, 0, 0, ex(1, 0, 0, 0, 0));
        vecs[5]  = mkv(0, 0, 0, ex(1, 0, 0, 0, 0));
        vecs[6]  = mkv(1, 1, 0, ex(1, 0, 0, 0, 0));
        vecs[7]  = mkv(0, 0, 1, ex(1, 0, 0, 0, 0));
        vecs[8]  = mkv(0, 0, 0, ex(1, 0, 0, 0, 0));
        vecs[9]  = mkv(0, 0, 0, ex(1, 0, 0, 0, 0));
        vecs[10] = mkv(0, 0, 0, ex(1, 0, 0, 0, 0));
        vecs[11] = mkv(0, 0, 0, ex(1, 0, 0, 0, 0));
        vecs[12] = mkv(0, 0, 0, ex(0, 0, 0, 0, 0));
        vecs[13] = mkv(1, 1, 0, ex(0, 0, 0, 1, 0));
        vecs[14] = mkv(1, 0, 0, ex(0, 0, 0, 1, 0));
        vecs[15] = mkv(1, 0, 0, ex(0, 0, 0, 1, 0));
        vecs[16] = mkv(1, 1, 0, ex(0, 0, 0, 0, 0));
        vecs[17] = mkv(0, 0, 0, ex(0, 1, 0, 0, 1));
        vecs[18] = mkv(0, 0, 0, ex(0, 0, 0, 0, 1));

        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", outs(), ex(0, 0, 0, 0, 0));
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].dv, vecs[i].din, vecs[i].ab, vecs[i].ld, vecs[i].ci);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Lockout after the third consecutive failure; correct frame during lockout ignored.
        send(4'b1001); step(0, 0, 0, 0, 0);
        check("fail2_pulse", outs(), ex(0, 1, 0, 0, 2));
        step(0, 0, 0, 0, 0);
        send(4'b1001); step(0, 0, 0, 0, 0);
        check("fail3_pulse", outs(), ex(0, 1, 0, 0, 3));
        cnt_lock = 0; seen_busy = 0; seen_unl = 0;
        for (int i = 0; i < 25; i++) begin
            if (i >= 1 && i <= 4) step(1'b1, (i == 2) ? 1'b0 : 1'b1, 0, 0, 0);
            else step(0, 0, 0, 0, 0);
            if (bus_if.locked_out) cnt_lock++;
            if (bus_if.busy) seen_busy++;
            if (bus_if.unlocked) seen_unl++;
        end
        check("lockout_len", cnt_lock, LOCKOUT_CYCLES);
        check("lockout_ignores_entry", seen_busy + seen_unl, 0);
        check("lockout_exit_cnt", outs(), ex(0, 0, 0, 0, 0));
        send(4'b1011); step(0, 0, 0, 0, 0);
        check("unlock_after_lockout", outs(), ex(1, 0, 0, 0, 0));
        idle(8);

        // Re-program during the 3rd unlock cycle; the window must not stretch.
        send(4'b1011);
        cnt_unl = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, (i == 3), 4'b0110);
            if (bus_if.unlocked) cnt_unl++;
        end
        check("reprog_window_len", cnt_unl, UNLOCK_CYCLES);
        send(4'b1011); step(0, 0, 0, 0, 0);
        check("old_code_fails", outs(), ex(0, 1, 0, 0, 1));
        step(0, 0, 0, 0, 0);
        send(4'b0110); step(0, 0, 0, 0, 0);
        check("new_code_unlocks", outs(), ex(1, 0, 0, 0, 0));
        idle(8);
        step(0, 0, 0, 1, 4'b1011);
        send(4'b1011); step(0, 0, 0, 0, 0);
        check("idle_load_ignored", outs(), ex(0, 1, 0, 0, 1));
        step(0, 0, 0, 0, 0);
        send(4'b0110); step(0, 0, 0, 0, 0);
        check("code_kept", outs(), ex(1, 0, 0, 0, 0));
        idle(8);

        // Abort keeps the failure count.
        send(4'b1001); idle(2);
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        check("partial_busy", outs(), ex(0, 0, 0, 1, 1));
        step(1, 1, 1, 0, 0);
        check("abort", outs(), ex(0, 0, 0, 0, 1));
        send(4'b0110); step(0, 0, 0, 0, 0);
        check("unlock_after_abort", outs(), ex(1, 0, 0, 0, 0));
        idle(8);

        // Asynchronous reset mid-frame restores the default code.
        send(4'b1001); idle(2);
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0);
        check("pre_reset", outs(), ex(0, 0, 0, 1, 1));
        #2 reset = 1'b1;
        #1 check("async_reset", outs(), ex(0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        send(4'b1011); step(0, 0, 0, 0, 0);
        check("default_code_after_reset", outs(), ex(1, 0, 0, 0, 0));
        idle(8);

`ifdef FSMLOCK_CTRL_ENTRY_TIMEOUT_EN
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        seen_fail = 0;
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
            step(0, 0, 0, 0, 0);
            if (bus_if.fail_pulse) seen_fail++;
        end
        check("before_timeout", outs(), ex(0, 0, 0, 1, 0));
        step(0, 0, 0, 0, 0);
        check("timeout_drop", outs(), ex(0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0);
        if (bus_if.fail_pulse) seen_fail++;
        check("timeout_no_fail", seen_fail, 0);
        send(4'b1011); step(0, 0, 0, 0, 0);
        check("unlock_after_timeout", outs(), ex(1, 0, 0, 0, 0));
        idle(8);
`else
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        seen_fail = 0;
        idle(TIMEOUT_CYCLES + 8);
        check("no_timeout_waits", outs(), ex(0, 0, 0, 1, 0));
        step(0, 0, 1, 0, 0);
        check("no_timeout_abort", outs(), ex(0, 0, 0, 0, 0));
`endif

        // Random traffic against the model.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            bit dv, d, ab, ld;
            logic [3:0] ci;
            if ($urandom_range(0, 699) == 0) begin
                reset = 1'b1;
                #1 model_reset();
                check("rand_reset", outs(), model_outs());
                @(negedge clk);
                reset = 1'b0;
            end
            dv = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom);
            ab = ($urandom_range(0, 19) == 0);
            ld = ($urandom_range(0, 7) == 0);
            ci = 4'($urandom);
            step(dv, d, ab, ld, ci);
            model_step(dv, d, ab, ld, ci);
            check($sformatf("rand%0d", i), outs(), model_outs());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
